// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch (port 0, read-only) and the LSQ (port 1).
// Round-robin grant, registered handshake outputs, and a watchdog that aborts hung accesses with bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [7:0]        cnt;
  logic              last_grant;
  logic              grant_port;
  logic              rsp_abort;
  logic [DATA_W-1:0] rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (if_req || ls_req) state_nx = ISSUE;
      ISSUE:   if (mem_rdy || cnt == TO_LAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_port = ls_req;
    if (if_req && ls_req) grant_port = ~last_grant;
    // success wins over abort when mem_rdy lands in the final watchdog cycle
    rsp_abort = ~mem_rdy;
    rsp_data  = '0;
    if (mem_rdy && !mem_we) rsp_data = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      ls_ack     <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      if_ack  <= 1'b0;
      ls_ack  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            owner      <= grant_port;
            last_grant <= grant_port;
            mem_req    <= 1'b1;
            mem_we     <= grant_port & ls_we;
            mem_addr   <= grant_port ? ls_addr : if_addr;
            mem_wdata  <= grant_port ? ls_wdata : '0;
            cnt        <= '0;
          end
        end
        ISSUE: begin
          if (state_nx == RESP) begin
            mem_req <= 1'b0;
            bus_err <= rsp_abort;
            if (owner) begin
              ls_ack   <= 1'b1;
              ls_rdata <= rsp_data;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rsp_data;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a 4-cycle watchdog: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration and memory handshake.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we, mem_rdy;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic        if_ack, ls_ack, mem_req, mem_we, owner, bus_err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .owner(owner), .bus_err(bus_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    if_req = 0; ls_req = 0; ls_we = 0; mem_rdy = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({if_ack, ls_ack, mem_req, mem_we, owner, bus_err} !== 6'b0 ||
        if_rdata !== 0 || ls_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_values got ctl=%b ifr=%h lsr=%h ma=%h mw=%h required all zero",
               {if_ack, ls_ack, mem_req, mem_we, owner, bus_err}, if_rdata, ls_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_fetch;
    do_reset;
    if_req = 1; if_addr = 32'h100;
    tick;
    checks++;
    if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h100 || if_ack !== 0) begin
      errors++;
      $display("FAIL fetch_issue got req=%b we=%b addr=%h ack=%b required 1 0 100 0", mem_req, mem_we, mem_addr, if_ack);
    end
    mem_rdy = 1; mem_rdata = 32'hDEADBEEF;
    tick;
    mem_rdy = 0;
    checks++;
    if (if_ack !== 1 || if_rdata !== 32'hDEADBEEF || ls_ack !== 0 || bus_err !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL fetch_ack got ack=%b data=%h ls_ack=%b err=%b req=%b required 1 deadbeef 0 0 0",
               if_ack, if_rdata, ls_ack, bus_err, mem_req);
    end
    if_req = 0;
    tick;
    checks++;
    if (if_ack !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL fetch_idle got ack=%b req=%b required 0 0", if_ack, mem_req);
    end
  endtask

  task automatic test_store_stall;
    do_reset;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      tick;
      checks++;
      if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678 || ls_ack !== 0) begin
        errors++;
        $display("FAIL store_hold cyc=%0d got req=%b we=%b addr=%h wd=%h ack=%b required 1 1 2000 12345678 0",
                 k, mem_req, mem_we, mem_addr, mem_wdata, ls_ack);
      end
      if (k == 4) begin mem_rdy = 1; mem_rdata = 32'hFFFF0000; end
    end
    tick;
    mem_rdy = 0;
    checks++;
    if (ls_ack !== 1 || ls_rdata !== 0 || if_ack !== 0 || owner !== 1 || bus_err !== 0) begin
      errors++;
      $display("FAIL store_ack got ack=%b data=%h if_ack=%b owner=%b err=%b required 1 0 0 1 0",
               ls_ack, ls_rdata, if_ack, owner, bus_err);
    end
    ls_req = 0; ls_we = 0;
    tick;
  endtask

  task automatic test_alternate;
    int c;
    logic exp_o;
    do_reset;
    c = 0;
    if_req = 1; if_addr = 32'hA00; ls_req = 1; ls_we = 0; ls_addr = 32'hB00;
    for (int i = 0; i < 4; i++) begin
      exp_o = i[0];
      tick; c++;
      checks++;
      if (owner !== exp_o || mem_req !== 1 || mem_addr !== (exp_o ? ls_addr : if_addr)) begin
        errors++;
        $display("FAIL alt_grant n=%0d got owner=%b addr=%h required %b %h", i, owner, mem_addr, exp_o,
                 exp_o ? ls_addr : if_addr);
      end
      mem_rdy = 1; mem_rdata = 32'h5000 + i;
      tick; c++;
      mem_rdy = 0;
      checks++;
      if (c != 2 + 3 * i || if_ack !== !exp_o || ls_ack !== exp_o ||
          (exp_o ? ls_rdata : if_rdata) !== 32'h5000 + i) begin
        errors++;
        $display("FAIL alt_ack n=%0d got cyc=%0d if_ack=%b ls_ack=%b data=%h required cyc=%0d owner=%b data=%h",
                 i, c, if_ack, ls_ack, exp_o ? ls_rdata : if_rdata, 2 + 3 * i, exp_o, 32'h5000 + i);
      end
      if (exp_o) ls_addr = ls_addr + 4; else if_addr = if_addr + 4;
      tick; c++;
      checks++;
      if (mem_req !== 0 || if_ack !== 0 || ls_ack !== 0) begin
        errors++;
        $display("FAIL alt_idle n=%0d got req=%b acks=%b%b required 0 00", i, mem_req, if_ack, ls_ack);
      end
    end
    if_req = 0; ls_req = 0;
  endtask

  task automatic test_timeout;
    do_reset;
    if_req = 1; if_addr = 32'h40; mem_rdy = 0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++;
      if (mem_req !== (c <= TO) || if_ack !== (c == TO + 1) || bus_err !== (c == TO + 1) || ls_ack !== 0 ||
          (c == TO + 1 && if_rdata !== 0)) begin
        errors++;
        $display("FAIL timeout cyc=%0d got req=%b ack=%b err=%b data=%h required req=%b ack=%b err=%b data=0",
                 c, mem_req, if_ack, bus_err, if_rdata, c <= TO, c == TO + 1, c == TO + 1);
      end
      if (c == TO + 1) if_req = 0;
    end
    ls_req = 1; ls_we = 0; ls_addr = 32'h77C;
    tick;
    checks++;
    if (mem_req !== 1 || owner !== 1 || mem_addr !== 32'h77C) begin
      errors++;
      $display("FAIL after_timeout_issue got req=%b owner=%b addr=%h required 1 1 77c", mem_req, owner, mem_addr);
    end
    mem_rdy = 1; mem_rdata = 32'h0BADCAFE;
    tick;
    mem_rdy = 0;
    checks++;
    if (ls_ack !== 1 || ls_rdata !== 32'h0BADCAFE || bus_err !== 0) begin
      errors++;
      $display("FAIL after_timeout_ack got ack=%b data=%h err=%b required 1 0badcafe 0", ls_ack, ls_rdata, bus_err);
    end
    ls_req = 0;
    tick;
  endtask

  task automatic test_boundary;
    do_reset;
    if_req = 1; if_addr = 32'h80;
    for (int c = 1; c <= TO; c++) begin
      tick;
      checks++;
      if (mem_req !== 1 || if_ack !== 0) begin
        errors++;
        $display("FAIL boundary_issue cyc=%0d got req=%b ack=%b required 1 0", c, mem_req, if_ack);
      end
      if (c == TO) begin mem_rdy = 1; mem_rdata = 32'hA5A5A5A5; end
    end
    tick;
    mem_rdy = 0;
    checks++;
    if (if_ack !== 1 || if_rdata !== 32'hA5A5A5A5 || bus_err !== 0) begin
      errors++;
      $display("FAIL boundary_ack got ack=%b data=%h err=%b required 1 a5a5a5a5 0", if_ack, if_rdata, bus_err);
    end
    if_req = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    ls_req = 1; ls_we = 0; ls_addr = 32'h300;
    tick;
    tick;
    checks++;
    if (mem_req !== 1 || owner !== 1) begin
      errors++;
      $display("FAIL midreset_pre got req=%b owner=%b required 1 1", mem_req, owner);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({if_ack, ls_ack, mem_req, mem_we, owner, bus_err} !== 6'b0 || mem_addr !== 0 || mem_wdata !== 0 ||
        if_rdata !== 0 || ls_rdata !== 0) begin
      errors++;
      $display("FAIL midreset_async got ctl=%b addr=%h required all zero",
               {if_ack, ls_ack, mem_req, mem_we, owner, bus_err}, mem_addr);
    end
    tick;
    reset = 0;
    if_req = 1; if_addr = 32'h900;
    tick;
    checks++;
    if (owner !== 0 || mem_req !== 1 || mem_addr !== 32'h900 || ls_ack !== 0) begin
      errors++;
      $display("FAIL midreset_tie got owner=%b req=%b addr=%h ls_ack=%b required 0 1 900 0",
               owner, mem_req, mem_addr, ls_ack);
    end
    mem_rdy = 1; mem_rdata = 32'h13579BDF;
    tick;
    mem_rdy = 0;
    checks++;
    if (if_ack !== 1 || if_rdata !== 32'h13579BDF || ls_ack !== 0) begin
      errors++;
      $display("FAIL midreset_ack got ack=%b data=%h ls_ack=%b required 1 13579bdf 0", if_ack, if_rdata, ls_ack);
    end
    if_req = 0; ls_req = 0;
    tick;
  endtask

  // Model: phase 0 waiting for a grant, 1 memory access outstanding, 2 acknowledge due.
  task automatic test_random;
    int          ph, cnt;
    logic        exp_owner, last_w, w, exp_err, x_we;
    logic        pend_if, pend_ls;
    logic [31:0] exp_rd, x_addr, x_wd, got_rd;
    do_reset;
    ph = 0; cnt = 0; last_w = 1; exp_owner = 0; exp_err = 0;
    pend_if = 0; pend_ls = 0; exp_rd = 0; x_addr = 0; x_wd = 0; x_we = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (mem_req !== (ph == 1) || owner !== exp_owner) begin
        errors++;
        $display("FAIL rand_req cyc=%0d got req=%b owner=%b required %b %b", cyc, mem_req, owner, ph == 1, exp_owner);
      end
      checks++;
      if (if_ack !== (ph == 2 && !exp_owner) || ls_ack !== (ph == 2 && exp_owner) ||
          bus_err !== (ph == 2 && exp_err)) begin
        errors++;
        $display("FAIL rand_ack cyc=%0d got if=%b ls=%b err=%b required %b %b %b", cyc, if_ack, ls_ack, bus_err,
                 ph == 2 && !exp_owner, ph == 2 && exp_owner, ph == 2 && exp_err);
      end
      if (ph == 1) begin
        checks++;
        if (mem_addr !== x_addr || mem_we !== x_we || (x_we && mem_wdata !== x_wd)) begin
          errors++;
          $display("FAIL rand_mem cyc=%0d got addr=%h we=%b wd=%h required %h %b %h",
                   cyc, mem_addr, mem_we, mem_wdata, x_addr, x_we, x_wd);
        end
      end
      if (ph == 2) begin
        got_rd = exp_owner ? ls_rdata : if_rdata;
        checks++;
        if (got_rd !== exp_rd) begin
          errors++;
          $display("FAIL rand_rdata cyc=%0d got %h required %h", cyc, got_rd, exp_rd);
        end
        if (exp_owner) pend_ls = 0; else pend_if = 0;
      end
      if (!pend_if && $urandom_range(0, 1) == 1) begin
        pend_if = 1; if_addr = $urandom;
      end
      if (!pend_ls && $urandom_range(0, 1) == 1) begin
        pend_ls = 1; ls_addr = $urandom; ls_we = ($urandom_range(0, 1) == 1); ls_wdata = $urandom;
      end
      if_req = pend_if; ls_req = pend_ls;
      mem_rdy = ($urandom_range(0, 9) < 3); mem_rdata = $urandom;
      case (ph)
        0: if (pend_if || pend_ls) begin
          w = (pend_if && pend_ls) ? !last_w : pend_ls;
          last_w = w; exp_owner = w;
          x_addr = w ? ls_addr : if_addr;
          x_we = w & ls_we;
          x_wd = ls_wdata;
          cnt = 0; ph = 1;
        end
        1: begin
          cnt++;
          if (mem_rdy) begin
            exp_rd = x_we ? 32'h0 : mem_rdata; exp_err = 0; ph = 2;
          end else if (cnt == TO) begin
            exp_rd = 32'h0; exp_err = 1; ph = 2;
          end
        end
        default: ph = 0;
      endcase
      tick;
    end
    if_req = 0; ls_req = 0; mem_rdy = 0;
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_store_stall;
    test_alternate;
    test_timeout;
    test_boundary;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
